// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA pattern sequencer.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } seq_state_t;

  localparam logic [3:0] BRIGHT_MAX = 4'd15;

  localparam logic [1:0] PAT_GRAD  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // Next pattern index, wrapping from npattern-1 back to the first pattern.
  function automatic logic [1:0] next_pattern(input logic [1:0] cur, input int npattern);
    return (int'(cur) >= npattern - 1) ? PAT_GRAD : cur + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability debouncer and a one-cycle
// pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter only runs while the synced input disagrees with the accepted
  // level, so any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer: steps PATTERN on frame boundaries, auto or manual.
// Define SEQ_FADE_EN to fade BRIGHT out and back in around each change.
module vga_pattern_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int DEBOUNCE_CYC    = 500000,
  parameter int NPATTERN        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VGA_VS,
  input  logic       BTN_NEXT,
  input  logic       BTN_MODE,
  output logic [1:0] PATTERN,
  output logic [3:0] BRIGHT,
  output logic       AUTO,
  output logic       BUSY
);

  import vga_seq_pkg::*;

  logic [2:0] vs_sr;
  logic       tick;
  logic       next_press;
  logic       mode_press;
  logic [9:0] frame_cnt;
  logic       pending;
  logic       wrap;
  logic       in_show;
  logic       step;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_next (
    .clk(CLK), .rst(RST), .btn(BTN_NEXT), .press(next_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_mode (
    .clk(CLK), .rst(RST), .btn(BTN_MODE), .press(mode_press)
  );

  // vs_sr[1:0] is the synchroniser, vs_sr[2] the edge-detect history.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) vs_sr <= 3'b000;
    else      vs_sr <= {vs_sr[1:0], VGA_VS};
  end

  // Tick on the end of the active-low sync pulse.
  assign tick = vs_sr[1] & ~vs_sr[2];

  // A counter wrap requests a change on the same tick it is detected.
  assign wrap = AUTO && (frame_cnt == 10'(FRAMES_PER_STEP - 1));
  assign step = tick && in_show && (pending || wrap);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AUTO      <= 1'b1;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      if (tick && in_show && AUTO)
        frame_cnt <= wrap ? 10'd0 : frame_cnt + 10'd1;
      if (mode_press) begin
        AUTO      <= ~AUTO;
        frame_cnt <= '0;
      end
      if (step)
        pending <= 1'b0;
      // A press coinciding with a tick survives to the following tick.
      if (next_press && in_show && !AUTO)
        pending <= 1'b1;
    end
  end

`ifdef SEQ_FADE_EN
  seq_state_t state;

  assign in_show = (state == SHOW);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= SHOW;
      BRIGHT  <= BRIGHT_MAX;
      BUSY    <= 1'b0;
      PATTERN <= PAT_GRAD;
    end else if (tick) begin
      case (state)
        SHOW: begin
          if (step) begin
            state  <= FADE_OUT;
            BRIGHT <= BRIGHT_MAX - 4'd1;
            BUSY   <= 1'b1;
          end
        end
        FADE_OUT: begin
          // Swap the pattern only while the screen is fully black.
          if (BRIGHT != 4'd0) begin
            BRIGHT <= BRIGHT - 4'd1;
          end else begin
            PATTERN <= next_pattern(PATTERN, NPATTERN);
            state   <= FADE_IN;
          end
        end
        FADE_IN: begin
          BRIGHT <= BRIGHT + 4'd1;
          if (BRIGHT == BRIGHT_MAX - 4'd1) begin
            state <= SHOW;
            BUSY  <= 1'b0;
          end
        end
        default: state <= SHOW;
      endcase
    end
  end
`else
  assign in_show = 1'b1;
  assign BRIGHT  = BRIGHT_MAX;
  assign BUSY    = 1'b0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      PATTERN <= PAT_GRAD;
    else if (step) PATTERN <= next_pattern(PATTERN, NPATTERN);
  end
`endif

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer; expected output changes are
// queued with the frame number in which they must appear.
module tb_vga_pattern_sequencer;

  localparam int W = 24;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       VGA_VS = 1'b0;
  logic       BTN_NEXT = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic [1:0] PATTERN;
  logic [3:0] BRIGHT;
  logic       AUTO;
  logic       BUSY;
  logic [7:0] outv;

  int   total = 0;
  int   bad = 0;
  int   fr = 0;
  bit   vs_run = 1'b0;
  bit   mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  vga_pattern_sequencer #(
    .FRAMES_PER_STEP(3),
    .DEBOUNCE_CYC(4),
    .NPATTERN(4)
  ) dut (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .BTN_NEXT(BTN_NEXT), .BTN_MODE(BTN_MODE),
    .PATTERN(PATTERN), .BRIGHT(BRIGHT), .AUTO(AUTO), .BUSY(BUSY)
  );

  assign outv = {PATTERN, AUTO, BRIGHT, BUSY};

  // ---------------- clock / frame generation ----------------
  always #5 CLK = ~CLK;

  // 100-cycle frames: 10 cycles of sync low, then high; fr counts rising edges.
  initial begin
    wait (vs_run);
    forever begin
      VGA_VS = 1'b0;
      repeat (10) @(negedge CLK);
      VGA_VS = 1'b1;
      fr++;
      repeat (90) @(negedge CLK);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got frame=%0d out=%h, want frame=%0d out=%h",
               name, act[23:8], act[7:0], exp[23:8], exp[7:0]);
    end
  endtask

  task automatic push(input int f, input logic [1:0] pat, input logic au,
                      input logic [3:0] br, input logic bz);
    exp_q.push_back({16'(f), pat, au, br, bz});
  endtask

  task automatic reset_check(input string name);
    check(name, {16'd0, outv}, {16'd0, 2'd0, 1'b1, 4'd15, 1'b0});
  endtask

  task automatic drain_check(input string name);
    check(name, W'(exp_q.size()), '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [7:0] last;
    last = '0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        last = outv;
      end else if (outv != last) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: frame=%0d out=%h, none expected", fr, outv);
        end else begin
          check("output_step", {16'(fr), outv}, exp_q.pop_front());
        end
        last = outv;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mid_frame(input int n);
    wait (fr == n);
    repeat (30) @(negedge CLK);
  endtask

  // Bounces of 2, 3 and 1 cycles, then a clean 6-cycle hold.
  task automatic mode_press();
    int hi[4] = '{2, 3, 1, 6};
    int lo[4] = '{2, 1, 2, 8};
    for (int i = 0; i < 4; i++) begin
      BTN_MODE = 1'b1;
      repeat (hi[i]) @(negedge CLK);
      BTN_MODE = 1'b0;
      repeat (lo[i]) @(negedge CLK);
    end
  endtask

  task automatic next_press();
    BTN_NEXT = 1'b1;
    repeat (8) @(negedge CLK);
    BTN_NEXT = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  // Reset asserted early in a sync-low phase so no spurious tick follows release.
  task automatic mid_reset(input int n);
    wait (fr == n);
    @(negedge VGA_VS);
    repeat (3) @(negedge CLK);
    drain_check("drained_before_reset");
    mon_en = 1'b0;
    RST = 1'b0;
    #1;
    reset_check("reset_async");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    reset_check("reset_after_release");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge CLK);
    reset_check("reset_hold");
    RST = 1'b1;
    @(negedge CLK);
    reset_check("reset_release");
    mon_en = 1'b1;
    vs_run = 1'b1;

`ifdef SEQ_FADE_EN
    push(1, 2'd0, 1'b0, 4'd15, 1'b0);
    mid_frame(1);
    mode_press();
    for (int i = 0; i <= 14; i++) push(3 + i, 2'd0, 1'b0, 4'(14 - i), 1'b1);
    push(18, 2'd1, 1'b0, 4'd0, 1'b1);
    for (int i = 1; i <= 15; i++) push(18 + i, 2'd1, 1'b0, 4'(i), (i == 15) ? 1'b0 : 1'b1);
    mid_frame(2);
    next_press();
    mid_frame(5);
    next_press();
    for (int i = 0; i <= 5; i++) push(35 + i, 2'd1, 1'b0, 4'(14 - i), 1'b1);
    mid_frame(34);
    next_press();
    mid_reset(40);
    push(43, 2'd0, 1'b1, 4'd14, 1'b1);
    push(44, 2'd0, 1'b1, 4'd13, 1'b1);
    mon_en = 1'b1;
    wait (fr == 45);
`else
    push(3,  2'd1, 1'b1, 4'd15, 1'b0);
    push(6,  2'd2, 1'b1, 4'd15, 1'b0);
    push(9,  2'd3, 1'b1, 4'd15, 1'b0);
    push(12, 2'd0, 1'b1, 4'd15, 1'b0);
    push(12, 2'd0, 1'b0, 4'd15, 1'b0);
    mid_frame(12);
    mode_press();
    push(14, 2'd1, 1'b0, 4'd15, 1'b0);
    mid_frame(13);
    next_press();
    push(16, 2'd2, 1'b0, 4'd15, 1'b0);
    mid_frame(15);
    next_press();
    // Debounced press lands exactly on tick 18, so it takes effect at tick 19.
    push(19, 2'd3, 1'b0, 4'd15, 1'b0);
    wait (fr == 17);
    @(negedge VGA_VS);
    repeat (6) @(negedge CLK);
    next_press();
    push(20, 2'd3, 1'b1, 4'd15, 1'b0);
    mid_frame(20);
    mode_press();
    push(23, 2'd0, 1'b1, 4'd15, 1'b0);
    mid_frame(21);
    next_press();
    push(24, 2'd0, 1'b0, 4'd15, 1'b0);
    mid_frame(24);
    mode_press();
    push(25, 2'd0, 1'b1, 4'd15, 1'b0);
    mid_frame(25);
    mode_press();
    push(28, 2'd1, 1'b1, 4'd15, 1'b0);
    mid_reset(29);
    push(32, 2'd1, 1'b1, 4'd15, 1'b0);
    mon_en = 1'b1;
    wait (fr == 33);
`endif
    repeat (20) @(negedge CLK);
    drain_check("drained_at_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: sequence stuck at frame=%0d, want completion", fr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
- Controls the pattern generator behind the VGA output.
- Selects which test pattern is displayed: gradation bands, colour bars, checker or solid.
- Advances the pattern automatically every N frames, or on a button press in manual mode.
- Changes pattern only on frame boundaries so the image never tears. Optionally fades brightness out and back in around each change.
- Sits between the board buttons, syncgen's VGA_VS and the pattern datapath, which consumes PATTERN and BRIGHT.

Parameters:
- FRAMES_PER_STEP, 60: frames shown per pattern in auto mode; legal range 1..1023.
- DEBOUNCE_CYC, 500000: CLK cycles a button level must stay stable before it is accepted (10 ms at 50 MHz).
- NPATTERN, 4: number of patterns; PATTERN wraps from NPATTERN-1 to 0.

Ports:
- CLK  in  1  system clock; all logic is in this single domain.
- RST  in  1  reset, asynchronous, active-low.
- VGA_VS  in  1  vertical sync from syncgen, active-low pulse; asynchronous to CLK.
- BTN_NEXT  in  1  raw push button, active-high; requests the next pattern.
- BTN_MODE  in  1  raw push button, active-high; toggles auto/manual mode.
- PATTERN  out  2  current pattern index.
- BRIGHT  out  4  brightness scale for the datapath; 15 = full, 0 = black.
- AUTO  out  1  1 = auto mode; drives an LED.
- BUSY  out  1  1 while a fade is in progress.

Behaviour:
- Reset (asynchronous, RST=0): PATTERN=0, BRIGHT=15, AUTO=1, BUSY=0, state SHOW, frame counter 0, pending=0, synchronisers and debouncers cleared to 0.
- Synchronisation: VGA_VS, BTN_NEXT and BTN_MODE each pass through a 2-FF synchroniser.
- Frame tick: a one-cycle pulse on the rising edge of the synced VGA_VS (end of the sync pulse).
- Debounce: the counter restarts whenever the synced input differs from the accepted level. After DEBOUNCE_CYC consecutive stable cycles the accepted level updates. A press is an accepted 0->1 transition, giving a one-cycle pulse.
- BTN_MODE press: toggles AUTO in any state and clears the frame counter. A fade already in progress always completes.
- Frame counter (10 bit):
  - Increments on a tick only when state is SHOW and AUTO=1.
  - On the tick where it equals FRAMES_PER_STEP-1 it wraps to 0 and sets pending.
- BTN_NEXT press:
  - SHOW and AUTO=0: sets pending.
  - SHOW and AUTO=1: ignored.
  - During a fade: ignored, not queued.
- pending is consumed only on a frame tick. A press and a tick in the same cycle: pending is set and the next tick consumes it.
- State machine (with SEQ_FADE_EN); all transitions happen on frame ticks only:
  - SHOW, pending at tick: go to FADE_OUT, BRIGHT<=14, clear pending, BUSY=1.
  - FADE_OUT, BRIGHT!=0: BRIGHT<=BRIGHT-1.
  - FADE_OUT, BRIGHT==0: PATTERN<=(PATTERN+1) mod NPATTERN, go to FADE_IN.
  - FADE_IN: BRIGHT<=BRIGHT+1; when the new value is 15, go to SHOW and set BUSY=0.
- Fade timing: the request tick is T0 (BRIGHT=14). BRIGHT reaches 0 at T14; PATTERN changes at T15; BRIGHT is 1..15 over T16..T30; SHOW is re-entered at T30.
- Output timing: all outputs are registered and change in the cycle after the tick.
- Reset mid-fade: immediate return to the reset values.

Optional Feature:
- Macro: SEQ_FADE_EN.
- Defined: the fade state machine above.
- Undefined:
  - No FADE states; BRIGHT is fixed at 15 and BUSY is fixed at 0.
  - SHOW with pending at a tick: PATTERN increments in that tick and pending clears.
  - BTN_NEXT is never ignored in manual mode.

Decomposition:
- Package vga_seq_pkg holds:
  - state encoding SHOW/FADE_OUT/FADE_IN;
  - BRIGHT_MAX=4'd15;
  - pattern index constants PAT_GRAD, PAT_BARS, PAT_CHECK, PAT_SOLID.
- Sub-module btn_debounce (synchroniser, debouncer and press-pulse generator, parameter DEBOUNCE_CYC), instantiated for each button.
- VGA_VS uses its own synchroniser and edge detector inside the top module.

Test Plan:
- Bench setup: DEBOUNCE_CYC=4, FRAMES_PER_STEP=3, VGA_VS period 100 CLK.
- Reset check: release reset -> PATTERN=0, BRIGHT=15, AUTO=1, BUSY=0; assert RST mid-fade -> outputs return to these values asynchronously.
- Auto mode, no fade: PATTERN goes 0->1 on the 3rd tick, ->2 on the 6th, 3->0 wraps on the 12th.
- Auto mode, SEQ_FADE_EN:
  - BUSY rises after tick 3.
  - BRIGHT goes 14..0 over the next ticks; PATTERN changes 15 ticks after the request tick.
  - BRIGHT returns to 15 and BUSY falls 30 ticks after the request tick.
- Debounce: BTN_MODE toggles with bounces shorter than 4 cycles, then stable high for 6 -> exactly one AUTO toggle (1->0).
- Manual mode: BTN_NEXT pressed mid-frame -> PATTERN changes only at the next tick. A press during a fade produces no extra pattern step.
- Coincident events: BTN_NEXT press in the same cycle as a tick (manual) -> pattern advances on the following tick, not this one.
